// File: rtl/serial_pattern_feeder.sv
// Serializes WIDTH-bit words accepted over valid/ready into a single idle-high bit line,
// with a per-bit valid strobe, an end-of-word pulse and an optional idle gap between words.
module serial_pattern_feeder #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    LAST_GAP = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state;
  logic             armed;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       gap_cnt;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // armed keeps data_ready low until the first edge after reset releases
  assign data_ready = armed && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      armed        <= 1'b0;
      sreg         <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b1;
      serial_valid <= 1'b0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      armed     <= 1'b1;
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid && armed) begin
            sreg         <= advance(data_in);
            serial_out   <= head_bit(data_in);
            serial_valid <= 1'b1;
            busy         <= 1'b1;
            bit_cnt      <= '0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            serial_out   <= 1'b1;
            serial_valid <= 1'b0;
            gap_cnt      <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt    <= bit_cnt + CW'(1);
            serial_out <= head_bit(sreg);
            sreg       <= advance(sreg);
            word_done  <= ((bit_cnt + CW'(1)) == LAST_BIT);
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          serial_out   <= 1'b1;
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: three instances (MSB-first gap 1, LSB-first gap 1, MSB-first gap 0)
// checked through a shared bit scoreboard plus cycle-exact hand sequences.
module tb_serial_pattern_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] din [3];
  logic [2:0] vld;
  logic [2:0] rdy, so, sv, wd, bsy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   sel;
    logic b;
    logic last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [7:0] seq;   // expected line order, seq[7] first
  } vec_t;

  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) u_def (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(vld[0]), .data_ready(rdy[0]),
    .serial_out(so[0]), .serial_valid(sv[0]), .word_done(wd[0]), .busy(bsy[0]));
  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1)) u_lsb (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(vld[1]), .data_ready(rdy[1]),
    .serial_out(so[1]), .serial_valid(sv[1]), .word_done(wd[1]), .busy(bsy[1]));
  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_b2b (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(vld[2]), .data_ready(rdy[2]),
    .serial_out(so[2]), .serial_valid(sv[2]), .word_done(wd[2]), .busy(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7 - i];
    return r;
  endfunction

  function automatic logic [7:0] model_seq(input int k, input logic [7:0] w);
    return (k == 1) ? rev8(w) : w;
  endfunction

  task automatic push_word(input int k, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) exp_q.push_back('{sel: k, b: seq[7 - i], last: (i == 7)});
  endtask

  // Scoreboard monitor: every valid bit must match the front of the queue.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sv[k]) begin
        chk("sb_bit_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t it;
          it = exp_q.pop_front();
          chk("sb_dut", k, it.sel);
          chk("sb_bit", int'(so[k]), int'(it.b));
          chk("sb_word_done", int'(wd[k]), int'(it.last));
        end
      end else begin
        chk("idle_no_word_done", int'(wd[k]), 0);
        chk("idle_line_high", int'(so[k]), 1);
      end
    end
  end

  task automatic send(input int k, input logic [7:0] w, input logic [7:0] seq);
    int n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", int'(rdy[k]), 1);
    din[k] = w;
    vld[k] = 1'b1;
    push_word(k, seq);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int k = 0; k < 3; k++) begin
      chk({name, "_so"}, int'(so[k]), 1);
      chk({name, "_sv"}, int'(sv[k]), 0);
      chk({name, "_wd"}, int'(wd[k]), 0);
      chk({name, "_busy"}, int'(bsy[k]), 0);
      chk({name, "_rdy"}, int'(rdy[k]), 0);
    end
  endtask

  vec_t vecs[10];
  int   accepts;

  initial begin
    vecs[0] = '{0, 8'h54, 8'b01010100};
    vecs[1] = '{1, 8'h54, 8'b00101010};
    vecs[2] = '{0, 8'hA5, 8'b10100101};
    vecs[3] = '{1, 8'hA5, 8'b10100101};
    vecs[4] = '{1, 8'h01, 8'b10000000};
    vecs[5] = '{0, 8'h01, 8'b00000001};
    vecs[6] = '{2, 8'h3C, 8'b00111100};
    vecs[7] = '{1, 8'hC0, 8'b00000011};
    vecs[8] = '{2, 8'h80, 8'b10000000};
    vecs[9] = '{0, 8'hFF, 8'b11111111};

    reset = 1'b1;
    vld   = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;

    // Power-up reset, released between edges.
    #2;
    chk_reset_outputs("por");
    #21;
    reset = 1'b0;
    #1;
    chk("rdy_before_edge", int'(rdy), 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", int'(rdy), 7);

    // Cycle-exact single word on the default instance.
    send(0, 8'h54, 8'b01010100);
    for (int c = 1; c <= 8; c++) begin
      logic [7:0] s;
      s = 8'b01010100;
      @(negedge clk);
      chk("w54_bit", int'(so[0]), int'(s[8 - c]));
      chk("w54_valid", int'(sv[0]), 1);
      chk("w54_done", int'(wd[0]), int'(c == 8));
      chk("w54_busy", int'(bsy[0]), 1);
      chk("w54_rdy_low", int'(rdy[0]), 0);
    end
    @(negedge clk);
    chk("gap_line", int'(so[0]), 1);
    chk("gap_valid", int'(sv[0]), 0);
    chk("gap_busy", int'(bsy[0]), 1);
    chk("gap_rdy", int'(rdy[0]), 0);
    @(negedge clk);
    chk("post_gap_rdy", int'(rdy[0]), 1);
    chk("post_gap_busy", int'(bsy[0]), 0);

    // Table vectors through the scoreboard.
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].sel, vecs[v].word, vecs[v].seq);
      drain();
    end

    // Random words using the order model.
    for (int r = 0; r < 6; r++) begin
      int         k;
      logic [7:0] w;
      k = r % 3;
      w = 8'($urandom_range(0, 255));
      send(k, w, model_seq(k, w));
      drain();
    end

    // Backpressure: valid held, data changing every cycle.
    accepts = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      din[0] = 8'h30 + 8'(c);
      vld[0] = 1'b1;
      if (rdy[0]) begin
        accepts++;
        push_word(0, din[0]);
      end
    end
    @(negedge clk);
    vld[0] = 1'b0;
    chk("bp_accepts", accepts, 3);
    drain();

    // Reset in the middle of 8'hA5, after its third bit.
    send(0, 8'hA5, 8'b10100101);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midword");
    exp_q.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rdy_before_edge", int'(rdy[0]), 0);
    repeat (4) @(negedge clk);
    chk("mid_no_bits", exp_q.size(), 0);
    send(0, 8'h54, 8'b01010100);
    @(negedge clk);
    chk("restart_first_bit", int'(so[0]), 0);
    chk("restart_valid", int'(sv[0]), 1);
    drain();

    // Back-to-back with no gap: 9-cycle word period.
    send(2, 8'hFF, 8'hFF);
    vld[2] = 1'b1;
    din[2] = 8'h00;
    push_word(2, 8'h00);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 9) begin
        chk("b2b_gap_valid", int'(sv[2]), 0);
        chk("b2b_gap_line", int'(so[2]), 1);
        chk("b2b_gap_rdy", int'(rdy[2]), 1);
      end else begin
        chk("b2b_valid", int'(sv[2]), 1);
      end
      if (c == 10) vld[2] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_valid", int'(sv[2]), 0);
    drain();

    // Asynchronous reset between edges while idle.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("async_rdy_back", int'(rdy), 7);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_pattern_feeder.md
# serial_pattern_feeder

Parallel-to-serial front end for the pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single-bit line, which drives the detector's `in` input directly. Between words the line idles high, which holds the detector in its idle state. A per-bit strobe and an end-of-word pulse let the bench and downstream logic align detections to word and bit positions.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYCLES, 1, idle-high cycles inserted after each word; legal range 0..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
- data_in  in  WIDTH  word to serialize; sampled only on the accepting edge.
- data_valid  in  1  upstream has a word on data_in.
- data_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  serial bit stream to the detector `in`; 1 when idle.
- serial_valid  out  1  high on cycles where serial_out carries a data bit.
- word_done  out  1  one-cycle pulse coincident with the last bit of a word.
- busy  out  1  high in SHIFT or GAP.

## Operation
- State machine: IDLE, SHIFT, GAP.
- IDLE:
  - data_ready=1, serial_out=1, serial_valid=0.
  - On a rising edge with data_valid=1: load the shift register from data_in, clear the bit counter, and go to SHIFT.
  - The first bit is registered onto serial_out at that same edge.
- SHIFT:
  - One bit per cycle for exactly WIDTH cycles; serial_valid=1 and data_ready=0.
  - MSB_FIRST=1: bit order WIDTH-1 down to 0. MSB_FIRST=0: bit order 0 up to WIDTH-1.
  - The bit counter is $clog2(WIDTH) bits wide and counts 0..WIDTH-1. It never wraps mid-word.
  - word_done=1 on the cycle that carries bit count WIDTH-1.
  - At the edge ending the last bit: go to GAP if GAP_CYCLES>0, otherwise go to IDLE.
- GAP:
  - serial_out=1, serial_valid=0, data_ready=0 for exactly GAP_CYCLES cycles.
  - The gap counter is 8 bits wide. Then go to IDLE.
- Handshake behaviour:
  - data_valid while data_ready=0 is ignored. It is not queued.
  - data_in changes after acceptance do not affect the word in flight.
- Reset:
  - On reset assertion, at any point including mid-word or mid-gap, the block goes immediately to IDLE.
  - The partial word is discarded and never resumed.
  - Output values during reset: serial_out=1, serial_valid=0, word_done=0, busy=0, data_ready=0.
  - data_ready rises on the first rising edge after reset deasserts.
  - Effect: the detector sees the line go high (idle), never a glitch-low bit.

## Timing
- Acceptance edge E (data_valid & data_ready sampled high at edge E):
  - First bit valid in cycle E+1.
  - Last bit in cycle E+WIDTH.
  - word_done in cycle E+WIDTH.
- GAP occupies cycles E+WIDTH+1 .. E+WIDTH+GAP_CYCLES.
- data_ready rises in cycle E+WIDTH+GAP_CYCLES+1.
- Word period: WIDTH+GAP_CYCLES+1 cycles. At GAP_CYCLES=0, one idle-high cycle still separates consecutive words.
- serial_out, serial_valid, word_done and busy are registered outputs, with no combinational path from inputs.
- data_ready is a decode of state only; it does not depend on data_valid.

## Test plan
- Reset values:
  - Assert reset asynchronously between edges -> all outputs take their reset values immediately.
  - After deassertion: data_ready=0 until the next edge, then 1.
- Single word, defaults (WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1):
  - Stimulus: 8'h54 accepted at edge E.
  - Response: serial_out = 0,1,0,1,0,1,0,0 in cycles E+1..E+8, serial_valid=1 throughout, word_done only at E+8.
  - serial_out=1 at E+9 and data_ready=1 at E+10.
  - The attached detector pulses DETECT on the pattern 01010.
- LSB first (MSB_FIRST=0):
  - Stimulus: 8'h54.
  - Response: bit sequence 0,0,1,0,1,0,1,0.
- Backpressure:
  - Stimulus: hold data_valid=1 and change data_in every cycle during SHIFT.
  - Response: the first word is emitted unchanged. The next acceptance occurs only when data_ready=1 and captures data_in at that edge.
- Reset mid-word:
  - Stimulus: assert reset after bit 3 of 8'hA5.
  - Response: serial_out=1 immediately and serial_valid=0. No further bits or word_done. The next word starts cleanly from its first bit.
- Back-to-back (GAP_CYCLES=0, data_valid held high):
  - Stimulus: words 8'hFF and 8'h00.
  - Response: word period of 9 cycles, with exactly one serial_out=1, serial_valid=0 cycle between the words.
